// File: rtl/onchip_ram_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip RAM between two
// Avalon-MM masters, with a fill engine that writes a constant to every word.
module onchip_ram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8192
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  input  logic                fill_start,
  input  logic [DATA_W-1:0]   fill_value,
  output logic                fill_busy,
  output logic                fill_done
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {ARB, FILL} state_e;

  state_e              state_q;
  logic                last_grant_q;  // 1: m1 was granted last, so m0 wins a tie
  logic                rd_pend_q;
  logic                rd_owner_q;
  logic                fill_busy_q;
  logic                fill_done_q;
  logic [ADDR_W-1:0]   fill_addr_q;
  logic [DATA_W-1:0]   fill_val_q;

  logic req0, req1, gnt0, gnt1, in_arb, rd_issue;

  assign in_arb   = (state_q == ARB);
  assign req0     = m0_read | m0_write;
  assign req1     = m1_read | m1_write;
  assign gnt0     = in_arb & req0 & (~req1 | last_grant_q);
  assign gnt1     = in_arb & req1 & (~req0 | ~last_grant_q);
  // read+write together is a write, so it must not produce readdatavalid
  assign rd_issue = (gnt0 & m0_read & ~m0_write) | (gnt1 & m1_read & ~m1_write);

  assign m0_waitrequest   = req0 & ~gnt0;
  assign m1_waitrequest   = req1 & ~gnt1;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rd_pend_q & ~rd_owner_q;
  assign m1_readdatavalid = rd_pend_q & rd_owner_q;
  assign fill_busy        = fill_busy_q;
  assign fill_done        = fill_done_q;
  assign mem_clken        = 1'b1;

  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    if (!in_arb) begin
      mem_address    = fill_addr_q;
      mem_byteenable = '1;
      mem_writedata  = fill_val_q;
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
    end else if (gnt1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_chipselect = 1'b1;
      mem_write      = m1_write;
    end else if (gnt0) begin
      mem_chipselect = 1'b1;
      mem_write      = m0_write;
    end
    // an aborting reset must not land a stray access in the RAM
    if (reset) begin
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB;
      last_grant_q <= 1'b1;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
      fill_busy_q  <= 1'b0;
      fill_done_q  <= 1'b0;
      fill_addr_q  <= '0;
      fill_val_q   <= '0;
    end else begin
      rd_pend_q   <= rd_issue;
      fill_done_q <= 1'b0;
      if (rd_issue) rd_owner_q <= gnt1;
      if (gnt0 | gnt1) last_grant_q <= gnt1;
      case (state_q)
        ARB: if (fill_start) begin
          state_q     <= FILL;
          fill_busy_q <= 1'b1;
          fill_addr_q <= '0;
          fill_val_q  <= fill_value;
        end
        FILL: if (fill_addr_q == LAST_ADDR) begin
          state_q     <= ARB;
          fill_busy_q <= 1'b0;
          fill_done_q <= 1'b1;
          fill_addr_q <= '0;
        end else begin
          fill_addr_q <= fill_addr_q + 1'b1;
        end
        default: state_q <= ARB;
      endcase
    end
  end
endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Directed plus random checks of onchip_ram_arbiter against a cycle-level
// behavioural model of the sharing rules and a word-array image of the RAM.
module tb_onchip_ram_arbiter;
  localparam int AW = 13, DW = 32, DEPTH = 16, NW = 8192;

  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0] m0_address, m1_address, mem_address;
  logic [3:0]    m0_byteenable, m1_byteenable, mem_byteenable;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata;
  logic          m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata, mem_readdata, fill_value;
  logic          fill_start, fill_busy, fill_done;

  always #5 clk = ~clk;

  onchip_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .fill_start(fill_start), .fill_value(fill_value),
    .fill_busy(fill_busy), .fill_done(fill_done)
  );

  // single-port RAM: registered read data, byte-enabled writes
  logic [DW-1:0] ram [0:NW-1];
  initial begin
    for (int i = 0; i < NW; i++) ram[i] = 32'(i) * 32'h9E3779B1;
    forever begin
      @(posedge clk);
      if (mem_chipselect && mem_clken) begin
        if (mem_write) begin
          for (int b = 0; b < 4; b++)
            if (mem_byteenable[b]) ram[mem_address][8*b +: 8] = mem_writedata[8*b +: 8];
        end else begin
          mem_readdata <= ram[mem_address];
        end
      end
    end
  end

  int errors = 0, checks = 0, done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // staged stimulus for the next cycle
  bit s_r0, s_w0, s_r1, s_w1, s_fs, s_rst;
  logic [AW-1:0] s_a0, s_a1;
  logic [3:0]    s_be0, s_be1;
  logic [31:0]   s_wd0, s_wd1, s_fv;

  // reference model
  logic [31:0] ref_mem [0:NW-1];
  bit m_prio1;            // 1: m1 wins the next tie
  bit m_fill;
  int m_faddr;
  logic [31:0] m_fval, exp_rdata;
  bit exp_rdv0, exp_rdv1, exp_busy, exp_done;

  task automatic idle();
    s_r0 = 0; s_w0 = 0; s_r1 = 0; s_w1 = 0; s_fs = 0; s_rst = 0;
    s_a0 = '0; s_a1 = '0; s_be0 = '0; s_be1 = '0; s_wd0 = '0; s_wd1 = '0; s_fv = '0;
  endtask

  task automatic cyc();
    bit rq0, rq1, g0, g1, w, was_fill;
    int a;
    logic [3:0] be;
    logic [31:0] wd;
    @(negedge clk);
    chk("rdv0", m0_readdatavalid, exp_rdv0);
    chk("rdv1", m1_readdatavalid, exp_rdv1);
    if (exp_rdv0 || exp_rdv1) begin
      chk("rdata0", m0_readdata, exp_rdata);
      chk("rdata1", m1_readdata, exp_rdata);
    end
    chk("fill_busy", fill_busy, exp_busy);
    chk("fill_done", fill_done, exp_done);
    if (fill_done) done_cnt++;
    if (s_rst) begin s_r0 = 0; s_w0 = 0; s_r1 = 0; s_w1 = 0; s_fs = 0; end
    reset = s_rst; fill_start = s_fs; fill_value = s_fv;
    m0_read = s_r0; m0_write = s_w0; m0_address = s_a0; m0_byteenable = s_be0; m0_writedata = s_wd0;
    m1_read = s_r1; m1_write = s_w1; m1_address = s_a1; m1_byteenable = s_be1; m1_writedata = s_wd1;
    #1;
    exp_rdv0 = 0; exp_rdv1 = 0; exp_done = 0;
    if (s_rst) begin
      m_prio1 = 0; m_fill = 0; m_faddr = 0; exp_busy = 0;
      return;
    end
    rq0 = s_r0 | s_w0; rq1 = s_r1 | s_w1;
    g0 = 0; g1 = 0;
    if (!m_fill) begin
      if (rq0 && rq1) begin g0 = !m_prio1; g1 = m_prio1; end
      else begin g0 = rq0; g1 = rq1; end
    end
    chk("wait0", m0_waitrequest, rq0 && !g0);
    chk("wait1", m1_waitrequest, rq1 && !g1);
    was_fill = m_fill;
    if (m_fill) begin
      chk("fill_cs", mem_chipselect, 1);
      chk("fill_we", mem_write, 1);
      chk("fill_be", mem_byteenable, 4'hF);
      chk("fill_addr", mem_address, m_faddr);
      chk("fill_data", mem_writedata, m_fval);
      ref_mem[m_faddr] = m_fval;
      if (m_faddr == DEPTH - 1) begin m_fill = 0; m_faddr = 0; exp_done = 1; end
      else m_faddr++;
    end else if (g0 || g1) begin
      w  = g0 ? s_w0 : s_w1;
      a  = g0 ? int'(s_a0) : int'(s_a1);
      be = g0 ? s_be0 : s_be1;
      wd = g0 ? s_wd0 : s_wd1;
      chk("cs", mem_chipselect, 1);
      chk("we", mem_write, w);
      chk("addr", mem_address, a);
      if (w) begin
        chk("be", mem_byteenable, be);
        chk("wdata", mem_writedata, wd);
        for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
      end else begin
        if (g0) exp_rdv0 = 1; else exp_rdv1 = 1;
        exp_rdata = ref_mem[a];
      end
      m_prio1 = g0;
    end else begin
      chk("cs_idle", mem_chipselect, 0);
      chk("we_idle", mem_write, 0);
    end
    if (!was_fill && s_fs) begin m_fill = 1; m_faddr = 0; m_fval = s_fv; end
    exp_busy = m_fill;
  endtask

  initial begin
    for (int i = 0; i < NW; i++) ref_mem[i] = 32'(i) * 32'h9E3779B1;
    idle();
    reset = 1; fill_start = 0; fill_value = '0;
    m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
    m_prio1 = 0; m_fill = 0; m_faddr = 0; m_fval = '0; exp_rdata = '0;
    exp_rdv0 = 0; exp_rdv1 = 0; exp_busy = 0; exp_done = 0;
    repeat (2) @(negedge clk);

    // both masters read continuously: m0 first after reset, then alternate
    s_r0 = 1; s_a0 = 13'd1; s_r1 = 1; s_a1 = 13'd2;
    repeat (6) cyc();
    idle(); cyc();

    // m0 write then read back, uncontended
    s_w0 = 1; s_a0 = 13'd5; s_be0 = 4'hF; s_wd0 = 32'hDEADBEEF; cyc();
    idle(); s_r0 = 1; s_a0 = 13'd5; cyc();
    idle(); cyc();
    chk("m0_deadbeef", m0_readdata, 32'hDEADBEEF);

    // m1 byte-lane merge
    s_w1 = 1; s_a1 = 13'd7; s_be1 = 4'hF; s_wd1 = 32'h11223344; cyc();
    s_be1 = 4'h1; s_wd1 = 32'h000000AA; cyc();
    idle(); s_r1 = 1; s_a1 = 13'd7; cyc();
    idle(); cyc();
    chk("m1_merge", m1_readdata, 32'h112233AA);

    // fill with m0 requesting throughout; second fill_start mid-fill ignored
    done_cnt = 0;
    s_r0 = 1; s_a0 = 13'd3; s_fs = 1; s_fv = 32'h0; cyc();
    s_fs = 0;
    for (int i = 0; i < 20; i++) begin
      s_fs = (i == 5); s_fv = 32'h55555555;
      cyc();
    end
    idle(); cyc();
    chk("done_once", done_cnt, 1);
    for (int i = 0; i < DEPTH; i++) begin idle(); s_r0 = 1; s_a0 = AW'(i); cyc(); end
    idle(); cyc();
    chk("fill_zero", m0_readdata, 32'h0);

    // reset part-way through a fill
    done_cnt = 0;
    s_fs = 1; s_fv = 32'h77777777; cyc();
    idle();
    for (int g = 0; g < 40 && !(m_fill && m_faddr == 8); g++) cyc();
    s_rst = 1; cyc();
    idle(); s_r0 = 1; s_a0 = 13'd9; s_r1 = 1; s_a1 = 13'd10;
    repeat (3) cyc();
    idle(); repeat (DEPTH) cyc();
    chk("no_done_after_reset", done_cnt, 0);

    // read+write together is a write
    s_r0 = 1; s_w0 = 1; s_a0 = 13'd20; s_be0 = 4'hF; s_wd0 = 32'hCAFEF00D; cyc();
    idle(); s_r0 = 1; s_a0 = 13'd20; cyc();
    idle(); cyc();
    chk("rw_is_write", m0_readdata, 32'hCAFEF00D);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      s_r0 = 1'($urandom); s_w0 = ($urandom_range(0, 3) == 0);
      s_r1 = 1'($urandom); s_w1 = ($urandom_range(0, 3) == 0);
      s_a0 = AW'($urandom_range(0, 31)); s_a1 = AW'($urandom_range(0, 31));
      s_be0 = 4'($urandom); s_be1 = 4'($urandom);
      s_wd0 = $urandom; s_wd1 = $urandom;
      s_fs = ($urandom_range(0, 79) == 0); s_fv = $urandom;
      s_rst = ($urandom_range(0, 199) == 0);
      cyc();
    end
    idle(); repeat (DEPTH + 2) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/onchip_ram_arbiter.md
Name: onchip_ram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port on-chip RAM (8192 x 32, byte enables, read data one cycle after address).
- Shares the one RAM port between two Avalon-MM-style masters (m0, m1) using round-robin arbitration.
- Returns read data with a per-master readdatavalid.
- Contains a fill engine that writes a constant to every word, e.g. to clear the RAM after boot.

Parameters:
ADDR_W, 13, word address width.
DATA_W, 32, data width; byte-enable width is DATA_W/8.
DEPTH, 8192, number of words filled by the fill engine; must be ≤ 2^ADDR_W.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
m0_address  in  ADDR_W  master 0 word address.
m0_byteenable  in  DATA_W/8  master 0 byte enables.
m0_read  in  1  master 0 read request.
m0_write  in  1  master 0 write request.
m0_writedata  in  DATA_W  master 0 write data.
m0_waitrequest  out  1  master 0 stall.
m0_readdata  out  DATA_W  master 0 read data.
m0_readdatavalid  out  1  master 0 read data valid.
m1_*  (same 8 ports as m0)  master 1.
mem_address  out  ADDR_W  to RAM address.
mem_byteenable  out  DATA_W/8  to RAM byteenable.
mem_chipselect  out  1  to RAM chipselect.
mem_write  out  1  to RAM write.
mem_writedata  out  DATA_W  to RAM writedata.
mem_clken  out  1  to RAM clken; tied 1.
mem_readdata  in  DATA_W  from RAM; valid the cycle after a read is issued.
fill_start  in  1  one-cycle pulse; starts a fill.
fill_value  in  DATA_W  word written by the fill engine; sampled at fill_start.
fill_busy  out  1  fill in progress.
fill_done  out  1  one-cycle pulse when the fill completes.

Behaviour:
- States: ARB, FILL. Reset value of every registered item:
  - state=ARB, last_grant=1 (so m0 wins the first tie).
  - rd_pend=0, rd_owner=0, fill_busy=0, fill_done=0, fill_addr=0.
- Request: req_x = mX_read | mX_write. If read and write are both high, the access is treated as a write.
- ARB grant (combinational, same cycle):
  - Only one master requesting: that master is granted.
  - Both requesting: the master ≠ last_grant is granted.
  - On every grant, last_grant updates at the clock edge.
- Waitrequest in ARB: mX_waitrequest = req_x & ~grant_x. A granted access completes in its request cycle, giving zero wait states when uncontended.
- Memory drive when granted: mem_chipselect=1, mem_write=the write request, and address/byteenable/writedata muxed from the granted master.
- Memory drive when nothing is granted: mem_chipselect=0, mem_write=0, other mem_* outputs don't-care (driven from m0).
- Read return: a read issued in cycle N gives mX_readdatavalid=1 for exactly one cycle at N+1, only for the issuing master (rd_pend/rd_owner registers). mX_readdata = mem_readdata for both masters.
- Throughput: back-to-back reads, one per cycle, are sustained.
- fill_start sampled in ARB:
  - Next state is FILL; fill_busy=1; fill_addr=0; fill_value is latched.
  - If fill_start coincides with a master request, the master's access is still granted that cycle and FILL begins next cycle.
- FILL, each cycle:
  - mem_chipselect=1, mem_write=1, mem_byteenable all ones, mem_address=fill_addr, mem_writedata=latched value; fill_addr increments.
  - Both waitrequests=1 whenever the master is requesting.
- FILL completion:
  - The cycle writing DEPTH-1 is the last fill cycle.
  - Next cycle: state=ARB, fill_busy=0, fill_done=1 for one cycle, fill_addr=0.
  - fill_addr never wraps past DEPTH-1.
- fill_start while fill_busy is ignored.
- A read issued the cycle before FILL entry still returns readdatavalid in the first FILL cycle.
- Reset mid-FILL: abort immediately to reset values; no fill_done; pending readdatavalid is dropped.
- Total fill time: DEPTH cycles plus 1 cycle to the fill_done pulse.

Test Plan:
- m0 writes 0xDEADBEEF to address 5 with byteenable 0xF, then reads address 5 -> no waitrequest; m0_readdatavalid high exactly 1 cycle after the read; m0_readdata = 0xDEADBEEF; m1_readdatavalid stays 0.
- m0 and m1 both read continuously (addresses 1 and 2) -> grants alternate m0, m1, m0, ...; each master waits every other cycle; data returned to the correct master.
- m1 write of 0x000000AA to address 7 with byteenable 0x1 over the prior word 0x11223344, then read -> 0x112233AA.
- fill_start with fill_value=0 and DEPTH=16 (reduced), with m0 requesting throughout -> 16 consecutive writes to addresses 0..15; m0_waitrequest=1 for those cycles; fill_done pulses once; m0 then granted; reads return 0.
- fill_start asserted again during a fill -> ignored, fill_done pulses only once; reset asserted at fill_addr=8 -> fill_busy=0 next cycle, no fill_done, arbitration resumes with m0 priority.
- m0 asserts read and write together -> treated as a write, no readdatavalid.
